// File: rtl/voice_phase_sequencer_pkg.sv
// Shared types and defaults for the voice phase sequencer.
// Optional wrap-limit arithmetic is selected by WRAP_LIMIT_EN.
package voice_phase_sequencer_pkg;

    localparam int unsigned VOICE_BITS_DEF = 3;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_HOST
    } seq_state_e;

endpackage

// File: rtl/voice_phase_sequencer_if.sv
// Host write handshake and single-port sample-position RAM bus.
// master = sequencer side, slave = RAM/host side.
interface voice_phase_sequencer_if
    import voice_phase_sequencer_pkg::*;
#(
    parameter int unsigned VOICE_BITS = VOICE_BITS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  host_req;
    logic [VOICE_BITS-1:0] host_voice;
    logic [DATA_WIDTH-1:0] host_data;
    logic                  host_ack;

    logic [VOICE_BITS-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        input  host_req, host_voice, host_data, ram_dout,
        output host_ack, ram_addr, ram_din, ram_we
    );

    modport slave (
        output host_req, host_voice, host_data, ram_dout,
        input  host_ack, ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/voice_phase_sequencer_phase_step.sv
// Combinational phase adder; with WRAP_LIMIT_EN the sum is folded back
// once by wrap_len, otherwise it wraps modulo 2**DATA_WIDTH.
module voice_phase_sequencer_phase_step
    import voice_phase_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
`ifdef WRAP_LIMIT_EN
    input  logic [DATA_WIDTH-1:0] wrap_len,
`endif
    input  logic [DATA_WIDTH-1:0] pos_in,
    input  logic [DATA_WIDTH-1:0] inc_in,
    output logic [DATA_WIDTH-1:0] step_out
);

`ifdef WRAP_LIMIT_EN
    logic [DATA_WIDTH:0] sum_full;
    logic [DATA_WIDTH:0] sum_fold;

    always_comb begin
        sum_full = {1'b0, pos_in} + {1'b0, inc_in};
        sum_fold = sum_full;
        // Compare on the carry-extended sum so overflow past 2**DATA_WIDTH still folds.
        if (sum_full >= {1'b0, wrap_len}) begin
            sum_fold = sum_full - {1'b0, wrap_len};
        end
        step_out = sum_fold[DATA_WIDTH-1:0];
    end
`else
    always_comb begin
        step_out = pos_in + inc_in;
    end
`endif

endmodule

// File: rtl/voice_phase_sequencer.sv
// Per-sample voice phase sweep with host write arbitration on one RAM port.
// WRAP_LIMIT_EN adds the wrap_len port and folded phase arithmetic.
module voice_phase_sequencer
    import voice_phase_sequencer_pkg::*;
#(
    parameter int unsigned VOICE_BITS = VOICE_BITS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic [DATA_WIDTH-1:0]  freq_inc,
    output logic [VOICE_BITS-1:0]  inc_voice,
`ifdef WRAP_LIMIT_EN
    input  logic [DATA_WIDTH-1:0]  wrap_len,
`endif
    voice_phase_sequencer_if.master bus,
    output logic [DATA_WIDTH-1:0]  pos_out,
    output logic [VOICE_BITS-1:0]  pos_voice,
    output logic                   pos_valid,
    output logic                   sweep_done,
    output logic                   overrun
);

    localparam int unsigned VOICES = 1 << VOICE_BITS;
    localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(VOICES - 1);
    localparam logic [VOICE_BITS-1:0] VOICE_ONE  = {{(VOICE_BITS-1){1'b0}}, 1'b1};

    seq_state_e            state_q, state_d;
    logic [VOICE_BITS-1:0] voice_q, voice_d;
    logic                  tick_pending_q, tick_pending_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [VOICE_BITS-1:0] pos_voice_q, pos_voice_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] step_sum;
    logic                  sweep_start;

    voice_phase_sequencer_phase_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_phase_step (
`ifdef WRAP_LIMIT_EN
        .wrap_len (wrap_len),
`endif
        .pos_in   (bus.ram_dout),
        .inc_in   (freq_inc),
        .step_out (step_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            voice_q        <= '0;
            tick_pending_q <= 1'b0;
            step_q         <= '0;
            pos_voice_q    <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            voice_q        <= voice_d;
            tick_pending_q <= tick_pending_d;
            step_q         <= step_d;
            pos_voice_q    <= pos_voice_d;
            overrun_q      <= overrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        voice_d        = voice_q;
        tick_pending_d = tick_pending_q;
        step_d         = step_q;
        pos_voice_d    = pos_voice_q;
        overrun_d      = overrun_q;
        sweep_start    = 1'b0;

        inc_voice    = '0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        bus.ram_we   = 1'b0;
        bus.host_ack = 1'b0;
        pos_valid    = 1'b0;
        sweep_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample_tick || tick_pending_q) begin
                    sweep_start = 1'b1;
                    state_d     = ST_READ;
                    voice_d     = '0;
                end else if (bus.host_req) begin
                    state_d = ST_HOST;
                end
            end

            ST_READ: begin
                inc_voice    = voice_q;
                bus.ram_addr = voice_q;
                step_d       = step_sum;
                pos_voice_d  = voice_q;
                state_d      = ST_WRITE;
            end

            ST_WRITE: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = voice_q;
                bus.ram_din  = step_q;
                pos_valid    = 1'b1;
                if (voice_q != LAST_VOICE) begin
                    voice_d = voice_q + VOICE_ONE;
                    state_d = ST_READ;
                end else begin
                    sweep_done = 1'b1;
                    // Last write makes the IDLE decision itself so a queued tick
                    // or waiting host write follows without a dead cycle.
                    if (sample_tick || tick_pending_q) begin
                        sweep_start = 1'b1;
                        state_d     = ST_READ;
                        voice_d     = '0;
                    end else if (bus.host_req) begin
                        state_d = ST_HOST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_HOST: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = bus.host_voice;
                bus.ram_din  = bus.host_data;
                bus.host_ack = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A starting sweep consumes one tick; a second simultaneous tick is dropped.
        if (sweep_start) begin
            tick_pending_d = 1'b0;
            if (sample_tick && tick_pending_q) begin
                overrun_d = 1'b1;
            end
        end else if (sample_tick) begin
            if (tick_pending_q) begin
                overrun_d = 1'b1;
            end else begin
                tick_pending_d = 1'b1;
            end
        end
    end

    assign pos_out   = step_q;
    assign pos_voice = pos_voice_q;
    assign overrun   = overrun_q;

endmodule
